// File: rtl/mux14_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 14-bit two-requester arbiter.
package mux14_rr_arbiter_pkg;

    localparam int DATA_W        = 14;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux14_rr_arbiter_mux.sv
// 14-bit 2:1 multiplexer: sel=0 passes inA, sel=1 passes inB.
module Mux14Bit2to1
    import mux14_rr_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] inA,
    input  logic [DATA_W-1:0] inB,
    input  logic              sel,
    output logic [DATA_W-1:0] out
);

    assign out = sel ? inB : inA;

endmodule

// File: rtl/mux14_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered 14-bit output slot.
// Ties go to the requester not served last; a draining slot can be refilled
// in the same cycle so back-to-back traffic runs at one word per clock.
module mux14_rr_arbiter
    import mux14_rr_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic [DATA_W-1:0] DataA,
    output logic              AckA,
    input  logic              ReqB,
    input  logic [DATA_W-1:0] DataB,
    output logic              AckB,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Sel,
    output logic [CNT_W-1:0]  CountA,
    output logic [CNT_W-1:0]  CountB
);

    arb_state_t        state;
    logic              last_b;
    logic              cap_en;
    logic              win_b;
    logic              any_req;
    logic [DATA_W-1:0] mux_data;

    // Capture decision, winner, Acks and select; all forced low during reset.
    always_comb begin
        cap_en  = (state == IDLE) || (OutValid && OutReady);
        any_req = ReqA || ReqB;
        win_b   = ReqB && (!ReqA || !last_b);
        AckA    = !Reset && cap_en && ReqA && !win_b;
        AckB    = !Reset && cap_en && win_b;
        if (Reset)
            Sel = 1'b0;
        else if (cap_en && any_req)
            Sel = win_b;
        else
            Sel = (state == HOLD_B);
    end

    Mux14Bit2to1 u_mux (
        .inA (DataA),
        .inB (DataB),
        .sel (Sel),
        .out (mux_data)
    );

    // Slot FSM: capture the winner, drain to IDLE, or hold under backpressure.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            OutData  <= '0;
            OutValid <= 1'b0;
            last_b   <= 1'b1;
            CountA   <= '0;
            CountB   <= '0;
        end else if (AckA || AckB) begin
            OutData  <= mux_data;
            OutValid <= 1'b1;
            last_b   <= AckB;
            if (AckB) begin
                state <= HOLD_B;
                if (CountB != {CNT_W{1'b1}})
                    CountB <= CountB + 1'b1;
            end else begin
                state <= HOLD_A;
                if (CountA != {CNT_W{1'b1}})
                    CountA <= CountA + 1'b1;
            end
        end else if (OutValid && OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux14_rr_arbiter.sv
// Directed bench for mux14_rr_arbiter: reset, single transfer, tie alternation,
// backpressure, counter saturation and asynchronous mid-transfer reset.
module tb_mux14_rr_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqA, ReqB, OutReady;
    logic [13:0] DataA, DataB;
    logic        AckA, AckB, OutValid, Sel;
    logic [13:0] OutData;
    logic [7:0]  CountA, CountB;

    int checks = 0;
    int errors = 0;

    mux14_rr_arbiter #(.CNT_W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqA     (ReqA),
        .DataA    (DataA),
        .AckA     (AckA),
        .ReqB     (ReqB),
        .DataB    (DataB),
        .AckB     (AckB),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sel      (Sel),
        .CountA   (CountA),
        .CountB   (CountB)
    );

    always #5 Clk = ~Clk;

    // advance to just after the next rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        Reset = 1'b1; ReqA = 0; ReqB = 0; OutReady = 0;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ReqA = 1'($urandom); ReqB = 1'($urandom); OutReady = 1'($urandom);
            DataA = 14'($urandom); DataB = 14'($urandom);
            #1;
            checks++;
            if ({OutValid, OutData, AckA, AckB, Sel, CountA, CountB} !== '0) begin
                errors++;
                $display("FAIL reset_state: got valid=%b data=%h ackA=%b ackB=%b sel=%b cA=%0d cB=%0d, want all 0",
                         OutValid, OutData, AckA, AckB, Sel, CountA, CountB);
            end
            step();
        end
        ReqA = 0; ReqB = 0; OutReady = 0;
        Reset = 1'b0;
    endtask

    task automatic test_single_a();
        step();
        ReqA = 1; DataA = 14'h1ABC; ReqB = 0; OutReady = 1;
        #1;
        checks++;
        if ({AckA, AckB, Sel} !== 3'b100) begin
            errors++;
            $display("FAIL single_ack: got ackA=%b ackB=%b sel=%b, want 1 0 0", AckA, AckB, Sel);
        end
        step();
        ReqA = 0;
        #1;
        checks++;
        if (OutValid !== 1'b1 || OutData !== 14'h1ABC || CountA !== 8'd1) begin
            errors++;
            $display("FAIL single_out: got valid=%b data=%h cA=%0d, want 1 1abc 1", OutValid, OutData, CountA);
        end
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got valid=%b, want 0", OutValid);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp;
        do_reset();
        ReqA = 1; ReqB = 1; DataA = 14'h0AAA; DataB = 14'h3555; OutReady = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (Sel !== 1'(i % 2) || AckA !== 1'(i % 2 == 0) || AckB !== 1'(i % 2)) begin
                errors++;
                $display("FAIL tie_sel[%0d]: got sel=%b ackA=%b ackB=%b, want sel=%0d", i, Sel, AckA, AckB, i % 2);
            end
            step();
            if (i == 5) begin ReqA = 0; ReqB = 0; end
            exp = (i % 2 == 0) ? 14'h0AAA : 14'h3555;
            checks++;
            if (OutValid !== 1'b1 || OutData !== exp) begin
                errors++;
                $display("FAIL tie_data[%0d]: got valid=%b data=%h, want 1 %h", i, OutValid, OutData, exp);
            end
        end
        checks++;
        if (CountA !== 8'd3 || CountB !== 8'd3) begin
            errors++;
            $display("FAIL tie_counts: got cA=%0d cB=%0d, want 3 3", CountA, CountB);
        end
        step();
    endtask

    task automatic test_backpressure();
        step();
        ReqA = 0; ReqB = 1; DataB = 14'h2222; OutReady = 0;
        #1;
        checks++;
        if (AckB !== 1'b1 || Sel !== 1'b1) begin
            errors++;
            $display("FAIL bp_ackB: got ackB=%b sel=%b, want 1 1", AckB, Sel);
        end
        step();
        ReqB = 0; ReqA = 1; DataA = 14'h1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (OutValid !== 1'b1 || OutData !== 14'h2222 || AckA !== 1'b0 || AckB !== 1'b0 || Sel !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ackA=%b ackB=%b sel=%b, want 1 2222 0 0 1",
                         i, OutValid, OutData, AckA, AckB, Sel);
            end
            step();
        end
        OutReady = 1;
        #1;
        checks++;
        if (AckA !== 1'b1 || Sel !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ackA=%b sel=%b, want 1 0", AckA, Sel);
        end
        step();
        ReqA = 0;
        checks++;
        if (OutValid !== 1'b1 || OutData !== 14'h1111) begin
            errors++;
            $display("FAIL bp_next: got valid=%b data=%h, want 1 1111", OutValid, OutData);
        end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        ReqA = 1; ReqB = 0; OutReady = 1;
        for (int i = 0; i < 260; i++) begin
            DataA = 14'(i);
            step();
            if (i == 254) begin
                checks++;
                if (CountA !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach: got cA=%0d, want 255", CountA);
                end
            end
        end
        ReqA = 0;
        checks++;
        if (CountA !== 8'd255 || CountB !== 8'd0 || OutData !== 14'd259) begin
            errors++;
            $display("FAIL sat_final: got cA=%0d cB=%0d data=%0d, want 255 0 259", CountA, CountB, OutData);
        end
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        ReqB = 1; DataB = 14'h3FFF; OutReady = 0;
        step();
        ReqB = 0;
        #1;
        checks++;
        if (OutValid !== 1'b1 || Sel !== 1'b1 || OutData !== 14'h3FFF) begin
            errors++;
            $display("FAIL mr_holdB: got valid=%b sel=%b data=%h, want 1 1 3fff", OutValid, Sel, OutData);
        end
        #1;
        ReqA = 1; ReqB = 1; DataA = 14'h0123; DataB = 14'h0456;
        Reset = 1;
        #1;
        checks++;
        if ({OutValid, OutData, AckA, AckB, Sel, CountA, CountB} !== '0) begin
            errors++;
            $display("FAIL mr_async: got valid=%b data=%h ackA=%b ackB=%b sel=%b cB=%0d, want all 0",
                     OutValid, OutData, AckA, AckB, Sel, CountB);
        end
        step();
        Reset = 0; OutReady = 1;
        #1;
        checks++;
        if (AckA !== 1'b1 || AckB !== 1'b0 || Sel !== 1'b0) begin
            errors++;
            $display("FAIL mr_tie: got ackA=%b ackB=%b sel=%b, want 1 0 0", AckA, AckB, Sel);
        end
        step();
        ReqA = 0; ReqB = 0;
        checks++;
        if (OutValid !== 1'b1 || OutData !== 14'h0123 || CountA !== 8'd1) begin
            errors++;
            $display("FAIL mr_capture: got valid=%b data=%h cA=%0d, want 1 0123 1", OutValid, OutData, CountA);
        end
    endtask

    initial begin
        Reset = 1; ReqA = 0; ReqB = 0; OutReady = 0; DataA = '0; DataB = '0;
        test_reset();
        test_single_a();
        test_back_to_back();
        test_backpressure();
        test_saturate();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
